csp_route_arb2x2: RTL and testbench
===================================

Name: csp_route_arb2x2

Overview:
- Clocked 2x2 router switch controller that schedules packets from two router input ports onto two output ports.
- Packet MSB selects the output port. Each output runs a round-robin arbiter between the two inputs.
- The granted packet passes through the left-shift routing update: the MSB is dropped, the remaining routing bits shift up, and a zero is inserted at the bottom of the routing field.
- One output register stage per port; sits between the input link buffers and the output link buffers of a router node.

Parameters:
- WIDTH, 11, packet width in bits.
- DATA_W, 6, low data bits passed unchanged (bits DATA_W-1..0).
- CNT_W, 8, width of the per-output packet counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in0_data  input  WIDTH  input port 0 packet.
- in0_valid  input  1  input 0 packet present.
- in0_ready  output  1  input 0 packet accepted this cycle.
- in1_data / in1_valid / in1_ready  same as in0, for input port 1.
- out0_data  output  WIDTH  output port 0 packet.
- out0_valid  output  1  output 0 register holds a packet.
- out0_ready  input  1  downstream accepts output 0.
- out1_data / out1_valid / out1_ready  same as out0, for output port 1.
- out0_cnt  output  CNT_W  packets delivered on output 0.
- out1_cnt  output  CNT_W  packets delivered on output 1.

Behaviour:
- Handshake:
  - A transfer occurs on a rising edge when valid and ready are both high.
  - Upstream holds data stable while valid && !ready.
  - Ready may depend combinationally on valid.
- Target: input i targets output in_i_data[WIDTH-1] (0 -> out0, 1 -> out1).
- Shift rule: out_data = {x[WIDTH-2:DATA_W], 1'b0, x[DATA_W-1:0]}. Bit WIDTH-1 is discarded.
- Output o can accept when !out_o_valid || out_o_ready. Draining and loading in the same cycle is allowed, giving full throughput.
- Arbiter per output o:
  - Requesters are the inputs with valid high and target o.
  - If there is one requester and o can accept, that input is granted.
  - If there are two requesters, the input other than last_o is granted.
  - last_o updates to the granted input on every grant.
  - Reset value of last_o is 1, so input 0 wins the first contention.
- in_i_ready = 1 only when input i is granted by its target output in this cycle. It is never high while in_i_valid is low.
- Latency: a packet accepted at edge N appears on out_o_data/out_o_valid after edge N (one cycle).
- Output register: out_o_data holds stable while out_o_valid && !out_o_ready. out_o_valid clears after a drain unless a new packet loads in the same edge.
- Parallel grants: in0 -> out1 and in1 -> out0, or in0 -> out0 and in1 -> out1, are both granted in the same cycle.
- Counters: out_o_cnt increments on each out_o_valid && out_o_ready edge and wraps modulo 2^CNT_W (255 -> 0 at default).
- Contention loser: keeps ready low and is granted on the next cycle the output can accept. With two persistent requesters, neither input waits more than one grant.
- Reset (any time, including mid-transfer):
  - outputs: out_valid=0, out_data=0, in_ready=0, counters=0.
  - internal: last_o=1.
  - Packets held in output registers are discarded.

Test Plan:
1. Reset: hold reset=0 with random inputs -> out*_valid=0, out*_data=0, in*_ready=0, out*_cnt=0. Release, all valid low -> all outputs unchanged.
2. Single route: in0_data=11'h5AA (MSB=1), in0_valid=1, out1_ready=1 -> in0_ready=1 in that cycle; next cycle out1_valid=1, out1_data=11'h32A; out1_cnt=1 after drain; out0_valid stays 0.
3. Contention: in0=11'h001 and in1=11'h002 (both MSB=0) held valid, out0_ready=1 -> out0 sequence 11'h001, 11'h002, 11'h001, ... strictly alternating, starting with in0.
4. Backpressure: out0 loaded with 11'h015, out0_ready=0 for 5 cycles while in1 requests out0 -> in1_ready=0 and out0_data=11'h015 stable. Raise out0_ready -> same edge drains and loads in1's shifted packet; cnt increments by 1.
5. Parallel: in0_data=11'h400 -> out1 and in1_data=11'h03F -> out0, both ready -> both accepted in the same cycle; out1_data=11'h000, out0_data=11'h03F.
6. Wrap and reset: deliver 256 packets on out0 -> out0_cnt goes 255 -> 0. Then assert reset while out1_valid=1 -> out1_valid drops asynchronously; after release the first contention grants in0.

Source files
------------

// File: rtl/csp_route_arb2x2.sv
// 2x2 router switch controller: MSB-routed packets, per-output round-robin
// arbitration, left-shift routing update and one registered stage per output.
module csp_route_arb2x2 #(
  parameter int WIDTH  = 11,
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] out0_cnt,
  output logic [CNT_W-1:0] out1_cnt
);

  logic [1:0][WIDTH-1:0] in_data;
  logic [1:0][WIDTH-1:0] shifted;
  logic [1:0]            in_valid;
  logic [1:0]            in_ready;
  logic [1:0]            out_ready;
  logic [1:0][1:0]       req;          // req[o][i]: input i wants output o
  logic [1:0]            can_accept;
  logic [1:0]            grant_valid;
  logic [1:0]            grant_sel;

  logic [1:0][WIDTH-1:0] out_data_reg;
  logic [1:0]            out_valid_reg;
  logic [1:0]            last_reg;
  logic [1:0][CNT_W-1:0] cnt_reg;

  assign in_data[0]   = in0_data;
  assign in_data[1]   = in1_data;
  assign in_valid     = {in1_valid, in0_valid};
  assign out_ready    = {out1_ready, out0_ready};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_in
      // Routing bit consumed: remaining routing bits move up, zero fills the gap.
      assign shifted[gi] = {in_data[gi][WIDTH-2:DATA_W], 1'b0, in_data[gi][DATA_W-1:0]};

      // Reset gating keeps ready low while the register stage is being cleared.
      assign in_ready[gi] = reset && in_valid[gi]
                            && grant_valid[in_data[gi][WIDTH-1]]
                            && (grant_sel[in_data[gi][WIDTH-1]] == 1'(gi));
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_out
      for (genvar gj = 0; gj < 2; gj++) begin : g_req
        assign req[gi][gj] = in_valid[gj] && (in_data[gj][WIDTH-1] == 1'(gi));
      end

      assign can_accept[gi]  = !out_valid_reg[gi] || out_ready[gi];
      assign grant_valid[gi] = can_accept[gi] && (|req[gi]);
      assign grant_sel[gi]   = (&req[gi]) ? ~last_reg[gi] : req[gi][1];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_reg <= '0;
      out_data_reg  <= '0;
      last_reg      <= '1;
      cnt_reg       <= '0;
    end else begin
      for (int o = 0; o < 2; o++) begin
        if (grant_valid[o]) begin
          out_data_reg[o]  <= shifted[grant_sel[o]];
          out_valid_reg[o] <= 1'b1;
          last_reg[o]      <= grant_sel[o];
        end else if (out_ready[o]) begin
          out_valid_reg[o] <= 1'b0;
        end
        if (out_valid_reg[o] && out_ready[o]) begin
          cnt_reg[o] <= cnt_reg[o] + CNT_W'(1);
        end
      end
    end
  end

  assign in0_ready  = in_ready[0];
  assign in1_ready  = in_ready[1];
  assign out0_data  = out_data_reg[0];
  assign out1_data  = out_data_reg[1];
  assign out0_valid = out_valid_reg[0];
  assign out1_valid = out_valid_reg[1];
  assign out0_cnt   = cnt_reg[0];
  assign out1_cnt   = cnt_reg[1];

endmodule

// File: tb/tb_csp_route_arb2x2.sv
// Directed bench for csp_route_arb2x2: stimulus pushes hand-computed output
// packets into per-port queues, a negedge monitor pops and compares them.
module tb_csp_route_arb2x2;

  localparam int WIDTH  = 11;
  localparam int DATA_W = 6;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in0_data, in1_data;
  logic             in0_valid, in1_valid;
  logic             in0_ready, in1_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic             out0_valid, out1_valid;
  logic             out0_ready, out1_ready;
  logic [CNT_W-1:0] out0_cnt, out1_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] exp_q0[$];
  logic [WIDTH-1:0] exp_q1[$];

  csp_route_arb2x2 #(.WIDTH(WIDTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out0_cnt(out0_cnt), .out1_cnt(out1_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " out0_valid"}, 32'(out0_valid), 0);
    check({tag, " out1_valid"}, 32'(out1_valid), 0);
    check({tag, " out0_data"},  32'(out0_data), 0);
    check({tag, " out1_data"},  32'(out1_data), 0);
    check({tag, " in0_ready"},  32'(in0_ready), 0);
    check({tag, " in1_ready"},  32'(in1_ready), 0);
    check({tag, " out0_cnt"},   32'(out0_cnt), 0);
    check({tag, " out1_cnt"},   32'(out1_cnt), 0);
  endtask

  // Monitor: one line per delivered output packet.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (reset && out0_valid && out0_ready) begin
        if (exp_q0.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL out0 unexpected packet: got %0h, expected none", out0_data);
        end else begin
          e = exp_q0.pop_front();
          $display("out0 deliver %03h (expect %03h) t=%0t", out0_data, e, $time);
          check("out0 data", 32'(out0_data), 32'(e));
        end
      end
      if (reset && out1_valid && out1_ready) begin
        if (exp_q1.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL out1 unexpected packet: got %0h, expected none", out1_data);
        end else begin
          e = exp_q1.pop_front();
          $display("out1 deliver %03h (expect %03h) t=%0t", out1_data, e, $time);
          check("out1 data", 32'(out1_data), 32'(e));
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    in0_data = '0; in1_data = '0; in0_valid = 0; in1_valid = 0;
    out0_ready = 0; out1_ready = 0;

    // 1. Reset held with random inputs
    #1;
    for (int k = 0; k < 4; k++) begin
      in0_data   = WIDTH'($urandom);
      in1_data   = WIDTH'($urandom);
      in0_valid  = 1'($urandom_range(0, 1));
      in1_valid  = 1'($urandom_range(0, 1));
      out0_ready = 1'($urandom_range(0, 1));
      out1_ready = 1'($urandom_range(0, 1));
      #1;
      check_idle("reset");
      tick();
    end
    in0_valid = 0; in1_valid = 0; out0_ready = 0; out1_ready = 0;
    in0_data = '0; in1_data = '0;
    reset = 1'b1;
    tick(); tick();
    check_idle("post-release");

    // 2. Single route in0 -> out1
    in0_data = 11'h5AA; in0_valid = 1; out1_ready = 1;
    exp_q1.push_back(11'h32A);
    #1;
    check("single in0_ready", 32'(in0_ready), 1);
    check("single in1_ready", 32'(in1_ready), 0);
    tick();
    in0_valid = 0;
    #1;
    check("single out1_valid", 32'(out1_valid), 1);
    check("single out1_data", 32'(out1_data), 32'h32A);
    check("single out0_valid", 32'(out0_valid), 0);
    tick();
    check("single out1_cnt", 32'(out1_cnt), 1);
    check("single out1_valid drained", 32'(out1_valid), 0);
    out1_ready = 0;

    // 3. Contention on out0, strict alternation starting with in0
    in0_data = 11'h001; in1_data = 11'h002; in0_valid = 1; in1_valid = 1; out0_ready = 1;
    for (int k = 0; k < 6; k++) exp_q0.push_back((k % 2 == 0) ? 11'h001 : 11'h002);
    for (int k = 0; k < 6; k++) begin
      #1;
      check("contend in0_ready", 32'(in0_ready), (k % 2 == 0) ? 1 : 0);
      check("contend in1_ready", 32'(in1_ready), (k % 2 == 0) ? 0 : 1);
      tick();
    end
    in0_valid = 0; in1_valid = 0;
    tick();
    check("contend out0_cnt", 32'(out0_cnt), 6);

    // 4. Backpressure on out0
    out0_ready = 0;
    in0_data = 11'h015; in0_valid = 1;
    exp_q0.push_back(11'h015);
    tick();
    in0_valid = 0;
    in1_data = 11'h0AB; in1_valid = 1;
    exp_q0.push_back(11'h12B);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp in1_ready", 32'(in1_ready), 0);
      check("bp out0_data", 32'(out0_data), 32'h015);
      check("bp out0_valid", 32'(out0_valid), 1);
      tick();
    end
    out0_ready = 1;
    #1;
    check("bp release in1_ready", 32'(in1_ready), 1);
    tick();
    in1_valid = 0;
    check("bp loaded out0_data", 32'(out0_data), 32'h12B);
    check("bp cnt after drain", 32'(out0_cnt), 7);
    tick();
    check("bp cnt final", 32'(out0_cnt), 8);

    // 5. Parallel grants
    in0_data = 11'h400; in0_valid = 1;
    in1_data = 11'h03F; in1_valid = 1;
    out0_ready = 1; out1_ready = 1;
    exp_q1.push_back(11'h000);
    exp_q0.push_back(11'h03F);
    #1;
    check("par in0_ready", 32'(in0_ready), 1);
    check("par in1_ready", 32'(in1_ready), 1);
    tick();
    in0_valid = 0; in1_valid = 0;
    check("par out1_data", 32'(out1_data), 32'h000);
    check("par out0_data", 32'(out0_data), 32'h03F);
    check("par out1_valid", 32'(out1_valid), 1);
    check("par out0_valid", 32'(out0_valid), 1);
    tick();
    check("par out0_cnt", 32'(out0_cnt), 9);
    check("par out1_cnt", 32'(out1_cnt), 2);

    // 6. Counter wrap on out0 (9 + 246 = 255, then one more)
    out1_ready = 0;
    for (int k = 0; k < 246; k++) begin
      in0_data = WIDTH'(k & 'h3F); in0_valid = 1;
      exp_q0.push_back(WIDTH'(k & 'h3F));
      tick();
    end
    in0_valid = 0;
    tick();
    check("wrap cnt 255", 32'(out0_cnt), 255);
    in0_data = 11'h02A; in0_valid = 1;
    exp_q0.push_back(11'h02A);
    tick();
    in0_valid = 0;
    check("wrap cnt still 255", 32'(out0_cnt), 255);
    tick();
    check("wrap cnt 0", 32'(out0_cnt), 0);

    // Reset mid-transfer with a packet held in out1; that packet is discarded
    in0_data = 11'h401; in0_valid = 1;
    tick();
    in0_valid = 0;
    check("pre-reset out1_valid", 32'(out1_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check("async out1_valid", 32'(out1_valid), 0);
    check("async out1_data", 32'(out1_data), 0);
    check("async out1_cnt", 32'(out1_cnt), 0);
    tick();
    reset = 1'b1;
    tick();

    // First contention after reset grants in0
    in0_data = 11'h002; in1_data = 11'h001; in0_valid = 1; in1_valid = 1; out0_ready = 1;
    exp_q0.push_back(11'h002);
    exp_q0.push_back(11'h001);
    #1;
    check("post-reset in0_ready", 32'(in0_ready), 1);
    check("post-reset in1_ready", 32'(in1_ready), 0);
    tick();
    #1;
    check("post-reset 2nd in1_ready", 32'(in1_ready), 1);
    tick();
    in0_valid = 0; in1_valid = 0;
    tick(); tick();
    check("post-reset out0_cnt", 32'(out0_cnt), 2);

    check("out0 queue drained", 32'(exp_q0.size()), 0);
    check("out1 queue drained", 32'(exp_q1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
